traffic_light_monitor: RTL and testbench
========================================

# traffic_light_monitor

Passive checker sitting on the controller's light outputs, the receiving end of the NS/EW lamp interface driven by `traffic_light_controller`. It decodes both 3-bit R/Y/G buses, tracks each direction's phase and dwell time, and flags encoding, conflict, sequence and timing violations. It has no effect on the controller. It is instantiated alongside the controller in simulation and on the lamp-driver side in hardware.

## Interface
- `MIN_GREEN`, 4: minimum legal green dwell, in cycles.
- `MAX_GREEN`, 8: maximum legal green dwell, in cycles.
- `YELLOW_CYCLES`, 2: exact legal yellow dwell, in cycles.
- `CNT_W`, 8: dwell counter width; the counter saturates at all-ones.
- `clk`  in  1  single clock; all logic samples on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `NS`  in  3  north-south lamps, {R,Y,G}; legal values are 100, 010 and 001.
- `EW`  in  3  east-west lamps, same encoding as `NS`.
- `clr`  in  1  synchronous clear of the latched fault.
- `fault`  out  1  sticky; set on the first violation.
- `fault_code`  out  3  code of the first violation; 0 means none.
- `ns_state`, `ew_state`  out  2  decoded phase per direction: 0=UNKNOWN, 1=RED, 2=GREEN, 3=YELLOW.
- `cycles`  out  16  number of completed NS green-to-green rounds (see Configuration).

## Operation
- **Input stage:** `NS` and `EW` are registered once; all checks use the registered values.
- **Per-direction tracker:**
  - Holds a phase state and a dwell counter `dur`. `dur` is 1 on the first sampled cycle of a colour and increments while the colour is held.
  - Legal transitions are GREEN→YELLOW, YELLOW→RED and RED→GREEN.
  - From UNKNOWN, the first valid colour is adopted with no sequence check. That first phase is marked partial and is exempt from the min-green and yellow-length checks.
- **Fault codes.** When several violations occur in the same cycle, the lowest code wins.
  - 1: `NS` not one-hot.
  - 2: `EW` not one-hot.
  - 3: conflict; both directions non-RED in the same cycle.
  - 4: illegal transition, e.g. G→R, Y→G or R→Y.
  - 5: yellow ended with `dur` ≠ `YELLOW_CYCLES`.
  - 6: green ended with `dur` < `MIN_GREEN`.
  - 7: green still held when `dur` reaches `MAX_GREEN`+1; raised once per phase.
- **Invalid encoding:** the tracker state is held and `dur` keeps counting.
- **Fault latching:**
  - The first violation sets `fault` and latches `fault_code`. Later violations are ignored until `clr`.
  - If `clr` and a new violation occur in the same cycle, the new violation is latched.
- **`cycles`:** increments on each NS RED→GREEN transition that is not from UNKNOWN. It wraps at 16'hFFFF.

## Timing
- **Reset:** `rst` asserted, including mid-phase, immediately forces `fault`=0, `fault_code`=0, both states to UNKNOWN, `dur`=0 and `cycles`=0.
- **Latency:**
  - A lamp value present at rising edge k is reflected in `ns_state`/`ew_state` after edge k.
  - A violation caused by that value is reflected in `fault`/`fault_code` after edge k+1.
- **Transition checks:** yellow/green length checks fire on the cycle in which the new colour is first sampled, using the `dur` of the colour just ended.
- **Counter saturation:** `dur` saturates at 2^`CNT_W`−1; the saturated value still triggers code 7.
- **`clr`:** takes effect at the next edge; `fault` is 0 after it unless the same-cycle rule above applies.

## Configuration
- **`TRAFFIC_MON_CYCLES_EN` defined:** the `cycles` counter is built as described.
- **Not defined:** `cycles` is tied to 0, and the round-detection logic is not synthesized.

## Structure
- **Package `traffic_mon_pkg`:**
  - lamp encodings (`LAMP_RED`=3'b100, `LAMP_YEL`=3'b010, `LAMP_GRN`=3'b001);
  - 2-bit phase state encoding;
  - 3-bit fault code constants.
- **Sub-module `traffic_dir_tracker`**, instantiated once per direction:
  - contains the decode, phase state, dwell counter, and sequence/timing checks;
  - outputs the decoded state plus one-hot violation strobes for codes 1/2 and 4–7.
- **Top level:** input registers, conflict check, priority select, fault latch and `cycles`.

## Test plan
All scenarios use `MIN_GREEN`=4, `MAX_GREEN`=8, `YELLOW_CYCLES`=2.
- **Legal run:** NS G×5, Y×2, R with EW mirrored, for 3 rounds → `fault`=0, `ns_state` follows 2→3→1, `cycles`=2 (first round partial).
- **Conflict:** NS=001 and EW=001 for one cycle → `fault`=1, `fault_code`=3 two edges later.
- **Illegal transition:** NS goes from 001 directly to 100 → `fault_code`=4. A later short yellow does not change the latched code.
- **Timing:**
  - yellow held 3 cycles → `fault_code`=5;
  - after `clr`, green of 3 cycles → 6;
  - after `clr`, green of 9 cycles → 7 on the 9th sampled cycle.
- **Bad encoding with simultaneous events:** NS=011 with an EW conflict in the same cycle → `fault_code`=1. `clr` pulsed in the same cycle as a new conflict → `fault` stays 1 with code 3.
- **Reset mid-phase:** assert `rst` during NS yellow → all outputs 0 and states UNKNOWN immediately. After release, a 1-cycle-remaining yellow raises no fault.

Source files
------------

// File: rtl/traffic_mon_pkg.sv
// rtl/traffic_mon_pkg.sv - lamp encodings, phase states and fault codes shared by the traffic monitor.
package traffic_mon_pkg;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    typedef enum logic [1:0] {
        PH_UNKNOWN = 2'd0,
        PH_RED     = 2'd1,
        PH_GREEN   = 2'd2,
        PH_YELLOW  = 2'd3
    } phase_e;

    typedef enum logic [2:0] {
        FC_NONE     = 3'd0,
        FC_NS_ENC   = 3'd1,
        FC_EW_ENC   = 3'd2,
        FC_CONFLICT = 3'd3,
        FC_SEQ      = 3'd4,
        FC_YEL_LEN  = 3'd5,
        FC_GRN_MIN  = 3'd6,
        FC_GRN_MAX  = 3'd7
    } fault_code_e;

    // Anything that is not exactly one lamp lit decodes to UNKNOWN.
    function automatic phase_e lamp_decode(input logic [2:0] lamp);
        case (lamp)
            LAMP_RED: return PH_RED;
            LAMP_GRN: return PH_GREEN;
            LAMP_YEL: return PH_YELLOW;
            default:  return PH_UNKNOWN;
        endcase
    endfunction

endpackage

// File: rtl/traffic_dir_tracker.sv
// rtl/traffic_dir_tracker.sv - per-direction phase/dwell tracker with encoding, sequence and timing checks.
module traffic_dir_tracker
    import traffic_mon_pkg::*;
#(
    parameter int MIN_GREEN     = 4,
    parameter int MAX_GREEN     = 8,
    parameter int YELLOW_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_vld_i,
    input  logic [2:0] lamp_i,
    output logic [1:0] state_o,
    output logic       viol_enc_o,
    output logic       viol_seq_o,
    output logic       viol_yel_o,
    output logic       viol_gmin_o,
    output logic       viol_gmax_o
);

    localparam int               DUR_MAX_I = (1 << CNT_W) - 1;
    localparam logic [CNT_W-1:0] DUR_MAX   = '1;
    localparam logic [CNT_W-1:0] YEL_LEN   = CNT_W'(YELLOW_CYCLES);
    localparam logic [CNT_W-1:0] MIN_LEN   = CNT_W'(MIN_GREEN);
    // A saturated counter must still be able to reach the max-green trip point.
    localparam logic [CNT_W-1:0] GMAX_TRIP = (MAX_GREEN + 1 > DUR_MAX_I) ? DUR_MAX : CNT_W'(MAX_GREEN + 1);

    phase_e           phase_q, phase_d, lamp_ph;
    logic [CNT_W-1:0] dur_q, dur_d, dur_inc;
    logic             partial_q, partial_d;
    logic             maxed_q, maxed_d;

    always_comb begin
        lamp_ph     = lamp_decode(lamp_i);
        dur_inc     = (dur_q == DUR_MAX) ? dur_q : dur_q + 1'b1;
        phase_d     = phase_q;
        dur_d       = dur_q;
        partial_d   = partial_q;
        maxed_d     = maxed_q;
        viol_enc_o  = 1'b0;
        viol_seq_o  = 1'b0;
        viol_yel_o  = 1'b0;
        viol_gmin_o = 1'b0;
        viol_gmax_o = 1'b0;
        if (sample_vld_i) begin
            if (lamp_ph == PH_UNKNOWN) begin
                viol_enc_o = 1'b1;
                dur_d      = dur_inc;
            end else if (phase_q == PH_UNKNOWN) begin
                phase_d   = lamp_ph;
                dur_d     = CNT_W'(1);
                partial_d = 1'b1;
                maxed_d   = 1'b0;
            end else if (lamp_ph != phase_q) begin
                viol_seq_o  = !((phase_q == PH_GREEN  && lamp_ph == PH_YELLOW) ||
                                (phase_q == PH_YELLOW && lamp_ph == PH_RED)    ||
                                (phase_q == PH_RED    && lamp_ph == PH_GREEN));
                viol_yel_o  = !partial_q && phase_q == PH_YELLOW && dur_q != YEL_LEN;
                viol_gmin_o = !partial_q && phase_q == PH_GREEN  && dur_q <  MIN_LEN;
                phase_d     = lamp_ph;
                dur_d       = CNT_W'(1);
                partial_d   = 1'b0;
                maxed_d     = 1'b0;
            end else begin
                dur_d = dur_inc;
                if (lamp_ph == PH_GREEN && dur_inc >= GMAX_TRIP && !maxed_q) begin
                    viol_gmax_o = 1'b1;
                    maxed_d     = 1'b1;
                end
            end
        end
    end

    // The decoded state shows the sample held in the input register, one edge ahead of phase_q.
    assign state_o = phase_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q   <= PH_UNKNOWN;
            dur_q     <= '0;
            partial_q <= 1'b0;
            maxed_q   <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            dur_q     <= dur_d;
            partial_q <= partial_d;
            maxed_q   <= maxed_d;
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - passive NS/EW lamp checker with sticky fault latch.
// Optional round counter on `cycles` built only when TRAFFIC_MON_CYCLES_EN is defined.
module traffic_light_monitor
    import traffic_mon_pkg::*;
#(
    parameter int MIN_GREEN     = 4,
    parameter int MAX_GREEN     = 8,
    parameter int YELLOW_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  NS,
    input  logic [2:0]  EW,
    input  logic        clr,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic [1:0]  ns_state,
    output logic [1:0]  ew_state,
    output logic [15:0] cycles
);

    logic [2:0]  ns_q, ew_q;
    logic        vld_q;
    logic        ns_enc, ns_seq, ns_yel, ns_gmin, ns_gmax;
    logic        ew_enc, ew_seq, ew_yel, ew_gmin, ew_gmax;
    logic        conflict, viol;
    fault_code_e code_d, code_q;
    logic        fault_q;

    // vld_q keeps the reset value of the input registers from being checked as a lamp sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ns_q  <= 3'b000;
            ew_q  <= 3'b000;
            vld_q <= 1'b0;
        end else begin
            ns_q  <= NS;
            ew_q  <= EW;
            vld_q <= 1'b1;
        end
    end

    traffic_dir_tracker #(
        .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN),
        .YELLOW_CYCLES(YELLOW_CYCLES), .CNT_W(CNT_W)
    ) u_ns (
        .clk(clk), .rst(rst), .sample_vld_i(vld_q), .lamp_i(ns_q), .state_o(ns_state),
        .viol_enc_o(ns_enc), .viol_seq_o(ns_seq), .viol_yel_o(ns_yel),
        .viol_gmin_o(ns_gmin), .viol_gmax_o(ns_gmax)
    );

    traffic_dir_tracker #(
        .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN),
        .YELLOW_CYCLES(YELLOW_CYCLES), .CNT_W(CNT_W)
    ) u_ew (
        .clk(clk), .rst(rst), .sample_vld_i(vld_q), .lamp_i(ew_q), .state_o(ew_state),
        .viol_enc_o(ew_enc), .viol_seq_o(ew_seq), .viol_yel_o(ew_yel),
        .viol_gmin_o(ew_gmin), .viol_gmax_o(ew_gmax)
    );

    assign conflict = vld_q && (ns_q != LAMP_RED) && (ew_q != LAMP_RED);

    always_comb begin
        code_d = FC_NONE;
        if (ns_enc)                    code_d = FC_NS_ENC;
        else if (ew_enc)               code_d = FC_EW_ENC;
        else if (conflict)             code_d = FC_CONFLICT;
        else if (ns_seq  || ew_seq)    code_d = FC_SEQ;
        else if (ns_yel  || ew_yel)    code_d = FC_YEL_LEN;
        else if (ns_gmin || ew_gmin)   code_d = FC_GRN_MIN;
        else if (ns_gmax || ew_gmax)   code_d = FC_GRN_MAX;
    end

    assign viol = (code_d != FC_NONE);

    // A violation arriving together with clr is latched rather than lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
        end else if (clr) begin
            fault_q <= viol;
            code_q  <= code_d;
        end else if (!fault_q && viol) begin
            fault_q <= 1'b1;
            code_q  <= code_d;
        end
    end

    assign fault      = fault_q;
    assign fault_code = code_q;

`ifdef TRAFFIC_MON_CYCLES_EN
    logic [1:0]  ns_state_q;
    logic [15:0] cycles_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ns_state_q <= PH_UNKNOWN;
            cycles_q   <= '0;
        end else begin
            ns_state_q <= ns_state;
            if (ns_state_q == PH_RED && ns_state == PH_GREEN)
                cycles_q <= cycles_q + 16'd1;
        end
    end

    assign cycles = cycles_q;
`else
    assign cycles = '0;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - randomized and directed bench for traffic_light_monitor against a lamp-history model.
module tb_traffic_light_monitor;

    localparam int MIN_G = 4;
    localparam int MAX_G = 8;
    localparam int YEL_N = 2;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [2:0]  NS, EW;
    logic        fault;
    logic [2:0]  fault_code;
    logic [1:0]  ns_state, ew_state;
    logic [15:0] cycles;

    traffic_light_monitor #(
        .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .YELLOW_CYCLES(YEL_N), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .NS(NS), .EW(EW), .clr(clr),
        .fault(fault), .fault_code(fault_code),
        .ns_state(ns_state), .ew_state(ew_state), .cycles(cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Model: colour of the last valid sample, samples since that colour began, and the latch.
    int m_ph[2];
    int m_run[2];
    bit m_part[2];
    bit m_maxed[2];
    int m_fault, m_code, m_pend_code, m_cycles;
    bit m_pend_round;

    function automatic int colour_of(input logic [2:0] l);
        if (l == R) return 1;
        if (l == G) return 2;
        if (l == Y) return 3;
        return 0;
    endfunction

    function automatic int exp_cycles();
`ifdef TRAFFIC_MON_CYCLES_EN
        return m_cycles;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ph[d] = 0; m_run[d] = 0; m_part[d] = 0; m_maxed[d] = 0;
        end
        m_fault = 0; m_code = 0; m_pend_code = 0; m_cycles = 0; m_pend_round = 0;
    endtask

    task automatic model_sample(input logic [2:0] ns, input logic [2:0] ew,
                                output int code, output bit round);
        bit [7:0] v;
        logic [2:0] lamp [2];
        int c;
        bit legal;
        v = '0;
        round = 0;
        lamp[0] = ns;
        lamp[1] = ew;
        for (int d = 0; d < 2; d++) begin
            c = colour_of(lamp[d]);
            if (c == 0) begin
                v[1 + d] = 1;
                m_run[d]++;
            end else if (m_ph[d] == 0) begin
                m_ph[d] = c; m_run[d] = 1; m_part[d] = 1; m_maxed[d] = 0;
            end else if (c != m_ph[d]) begin
                legal = (m_ph[d] == 2 && c == 3) || (m_ph[d] == 3 && c == 1) || (m_ph[d] == 1 && c == 2);
                if (!legal) v[4] = 1;
                if (!m_part[d] && m_ph[d] == 3 && m_run[d] != YEL_N) v[5] = 1;
                if (!m_part[d] && m_ph[d] == 2 && m_run[d] < MIN_G) v[6] = 1;
                if (d == 0 && m_ph[d] == 1 && c == 2) round = 1;
                m_ph[d] = c; m_run[d] = 1; m_part[d] = 0; m_maxed[d] = 0;
            end else begin
                m_run[d]++;
                if (c == 2 && m_run[d] > MAX_G && !m_maxed[d]) begin
                    v[7] = 1;
                    m_maxed[d] = 1;
                end
            end
        end
        if (ns != R && ew != R) v[3] = 1;
        code = 0;
        for (int k = 7; k >= 1; k--) if (v[k]) code = k;
    endtask

    // Called just after a negedge; returns just after the following negedge.
    task automatic step(input logic [2:0] ns, input logic [2:0] ew, input bit c);
        int code;
        bit rnd;
        NS = ns; EW = ew; clr = c;
        @(posedge clk);
        if (c) begin
            m_fault = (m_pend_code != 0);
            m_code  = m_pend_code;
        end else if (m_fault == 0 && m_pend_code != 0) begin
            m_fault = 1;
            m_code  = m_pend_code;
        end
        if (m_pend_round) m_cycles = (m_cycles + 1) & 16'hFFFF;
        model_sample(ns, ew, code, rnd);
        m_pend_code  = code;
        m_pend_round = rnd;
        #1;
        check_eq("ns_state", ns_state, m_ph[0]);
        check_eq("ew_state", ew_state, m_ph[1]);
        check_eq("fault", fault, m_fault);
        check_eq("fault_code", fault_code, m_code);
        check_eq("cycles", cycles, exp_cycles());
        @(negedge clk);
    endtask

    task automatic run(input logic [2:0] ns, input logic [2:0] ew, input int n);
        for (int i = 0; i < n; i++) step(ns, ew, 1'b0);
    endtask

    task automatic reset_mid();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("rst_fault", fault, 0);
        check_eq("rst_code", fault_code, 0);
        check_eq("rst_ns_state", ns_state, 0);
        check_eq("rst_ew_state", ew_state, 0);
        check_eq("rst_cycles", cycles, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, yl;
        bit ns_turn;
        logic [2:0] a, ns, ew;

        rst = 1'b1; clr = 1'b0; NS = R; EW = R;
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("init_fault", fault, 0);
        check_eq("init_ns_state", ns_state, 0);
        rst = 1'b0;

        // Legal run: three rounds, first NS green is partial.
        for (int r = 0; r < 3; r++) begin
            run(G, R, 5); run(Y, R, 2); run(R, G, 5); run(R, Y, 2);
        end
        check_eq("legal_fault", fault, 0);
`ifdef TRAFFIC_MON_CYCLES_EN
        check_eq("legal_cycles", cycles, 2);
`else
        check_eq("legal_cycles", cycles, 0);
`endif

        // Conflict.
        reset_mid();
        run(G, R, 2);
        step(G, G, 1'b0);
        check_eq("conflict_latency", fault, 0);
        step(G, R, 1'b0);
        check_eq("conflict_fault", fault, 1);
        check_eq("conflict_code", fault_code, 3);

        // Illegal transition, later short yellow ignored.
        reset_mid();
        run(G, R, 5); run(R, R, 2); run(G, R, 4); run(Y, R, 1); run(R, R, 2);
        check_eq("seq_code", fault_code, 4);

        // Timing: long yellow, short green, long green.
        reset_mid();
        run(G, R, 5); run(Y, R, 3); run(R, R, 2);
        check_eq("yel_code", fault_code, 5);
        step(R, R, 1'b1);
        check_eq("clr_fault", fault, 0);
        run(G, R, 3); run(Y, R, 2); run(R, R, 1);
        check_eq("gmin_code", fault_code, 6);
        step(R, R, 1'b1);
        run(G, R, 9);
        check_eq("gmax_not_yet", fault, 0);
        step(Y, R, 1'b0);
        check_eq("gmax_code", fault_code, 7);
        run(Y, R, 1); run(R, R, 2);

        // Bad encoding beats conflict; clr coincident with a new conflict.
        reset_mid();
        run(G, R, 5);
        step(3'b011, G, 1'b0);
        step(G, R, 1'b0);
        check_eq("enc_code", fault_code, 1);
        step(G, G, 1'b0);
        step(G, R, 1'b1);
        check_eq("clr_conflict_fault", fault, 1);
        check_eq("clr_conflict_code", fault_code, 3);

        // Reset mid-yellow, then the remaining yellow is a partial phase.
        reset_mid();
        run(G, R, 5); run(Y, R, 1);
        reset_mid();
        run(Y, R, 1); run(R, R, 3);
        check_eq("post_rst_fault", fault, 0);

        // Randomized alternating controller with injected garbage, clears and resets.
        for (int seg = 0; seg < 60; seg++) begin
            g = $urandom_range(3, 9);
            yl = $urandom_range(1, 3);
            ns_turn = (seg % 2 == 0);
            for (int i = 0; i < g + yl; i++) begin
                a  = (i < g) ? G : Y;
                ns = ns_turn ? a : R;
                ew = ns_turn ? R : a;
                if ($urandom_range(0, 29) == 0) ns = 3'($urandom);
                if ($urandom_range(0, 29) == 0) ew = 3'($urandom);
                step(ns, ew, $urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 19) == 0) reset_mid();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
